// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, accumulator state type and digit check
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_ADJ = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } acc_state_t;

    // True when the nibble is a legal BCD digit (0..9)
    function automatic logic is_bcd(input logic [BCD_W-1:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - single-digit BCD adder with carry in/out
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             cin,
    output logic [BCD_W-1:0] s,
    output logic             cout
);

    logic [BCD_W:0] raw;

    // Binary add, then decimal-adjust by 6 when the digit exceeds 9
    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
        s    = raw[BCD_W-1:0];
        cout = 1'b0;
        if (raw > {1'b0, BCD_MAX}) begin
            s    = raw[BCD_W-1:0] + BCD_ADJ;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_accumulator.sv
// rtl/bcd_accumulator.sv - digit-serial BCD running-sum accumulator driven by a go key
module bcd_accumulator
    import bcd_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      CLOCK_50,
    input  logic                      Reset,
    input  logic                      go,
    input  logic                      clr,
    input  logic [BCD_W*DIGITS-1:0]   SW_X,
    output logic [BCD_W*DIGITS-1:0]   sum_bcd,
    output logic                      busy,
    output logic                      done,
    output logic                      ovf,
    output logic                      err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    acc_state_t state, state_nxt;

    logic                          sync_last;
    logic                          hist_q;
    logic                          req;
    logic                          opnd_ok;
    logic [DIGITS-1:0][BCD_W-1:0]  sum_q;
    logic [DIGITS-1:0][BCD_W-1:0]  opnd_q;
    logic [IDX_W-1:0]              idx_q;
    logic                          carry_q;
    logic                          ovf_q;
    logic                          err_q;
    logic [BCD_W-1:0]              add_s;
    logic                          add_cout;

    genvar g;
    generate
        for (g = 0; g < SYNC_STAGES; g++) begin : g_sync
            logic q;
            if (g == 0) begin : g_first
                // First synchroniser flop samples the raw asynchronous key
                always_ff @(posedge CLOCK_50 or posedge Reset) begin
                    if (Reset)    q <= 1'b0;
                    else if (clr) q <= 1'b0;
                    else          q <= go;
                end
            end else begin : g_next
                // Remaining flops settle metastability stage by stage
                always_ff @(posedge CLOCK_50 or posedge Reset) begin
                    if (Reset)    q <= 1'b0;
                    else if (clr) q <= 1'b0;
                    else          q <= g_sync[g-1].q;
                end
            end
        end
    endgenerate

    assign sync_last = g_sync[SYNC_STAGES-1].q;

    // History flop turns the synchronised level into a one-cycle rising-edge request
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset)    hist_q <= 1'b0;
        else if (clr) hist_q <= 1'b0;
        else          hist_q <= sync_last;
    end

    assign req = sync_last & ~hist_q;

    // Operand is accepted only if every digit is legal BCD
    always_comb begin
        opnd_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(SW_X[i*BCD_W +: BCD_W])) opnd_ok = 1'b0;
        end
    end

    bcd_digit_add u_digit_add (
        .a    (sum_q[idx_q]),
        .b    (opnd_q[idx_q]),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_cout)
    );

    // State register
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; requests outside IDLE are simply ignored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req && opnd_ok) state_nxt = ADD;
            ADD:     if (idx_q == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    // Datapath: operand capture, serial digit add, sticky flags
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset || clr) begin
            sum_q   <= '0;
            opnd_q  <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        opnd_q <= SW_X;
                        if (opnd_ok) begin
                            err_q   <= 1'b0;
                            idx_q   <= '0;
                            carry_q <= 1'b0;
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end
                end
                ADD: begin
                    sum_q[idx_q] <= add_s;
                    carry_q      <= add_cout;
                    idx_q        <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) ovf_q <= ovf_q | add_cout;
                end
                default: ;
            endcase
        end
    end

    assign sum_bcd = sum_q;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign ovf     = ovf_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_accumulator.sv
// tb/tb_bcd_accumulator.sv - directed self-checking bench for bcd_accumulator
module tb_bcd_accumulator;

    logic       CLOCK_50 = 1'b0;
    logic       Reset;
    logic       go;
    logic       clr;
    logic [7:0] SW_X;
    logic [7:0] sum_bcd;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

    bcd_accumulator #(
        .DIGITS      (2),
        .SYNC_STAGES (2)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .go       (go),
        .clr      (clr),
        .SW_X     (SW_X),
        .sum_bcd  (sum_bcd),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .err      (err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // {sum, busy, done, ovf, err}
    function automatic logic [31:0] outs();
        return {20'd0, sum_bcd, busy, done, ovf, err};
    endfunction

    function automatic logic [31:0] mk(input logic [7:0] s, input logic b, input logic d,
                                       input logic o, input logic e);
        return {20'd0, s, b, d, o, e};
    endfunction

    // One-cycle go pulse; returns cycles to done and number of busy samples
    task automatic press(input logic [7:0] sw, output int lat, output int bcnt);
        @(negedge CLOCK_50);
        SW_X = sw;
        go   = 1'b1;
        lat  = -1;
        bcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLOCK_50);
            if (i == 1) go = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_add(input string tag, input logic [7:0] sw, input logic [7:0] exp_sum,
                          input logic exp_ovf);
        int lat, bcnt;
        press(sw, lat, bcnt);
        check({tag, " latency"}, lat, 5);
        check({tag, " busy cycles"}, bcnt, 3);
        @(negedge CLOCK_50);
        check({tag, " result"}, outs(), mk(exp_sum, 1'b0, 1'b0, exp_ovf, 1'b0));
    endtask

    task automatic bad_press(input logic [7:0] sw, output int bcnt);
        @(negedge CLOCK_50);
        SW_X = sw;
        go   = 1'b1;
        bcnt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLOCK_50);
            if (i == 1) go = 1'b0;
            if (busy) bcnt++;
        end
    endtask

    initial begin
        int bcnt, dones;
        Reset = 1'b1;
        go    = 1'b0;
        clr   = 1'b0;
        SW_X  = 8'h00;
        repeat (3) @(negedge CLOCK_50);
        Reset = 1'b0;
        @(negedge CLOCK_50);
        check("reset state", outs(), mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));

        do_add("add 27", 8'h27, 8'h27, 1'b0);
        do_add("add 45", 8'h45, 8'h72, 1'b0);
        do_add("add 39 wrap", 8'h39, 8'h11, 1'b1);
        do_add("add 88", 8'h88, 8'h99, 1'b1);
        do_add("add 01 ripple", 8'h01, 8'h00, 1'b1);

        bad_press(8'h3A, bcnt);
        check("bad operand busy", bcnt, 0);
        check("bad operand flags", outs(), mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1));
        bad_press(8'hA3, bcnt);
        check("bad top digit", outs(), mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1));
        do_add("add 05 clears err", 8'h05, 8'h05, 1'b1);

        // Level held high for 50 cycles gives exactly one add
        @(negedge CLOCK_50);
        SW_X  = 8'h01;
        go    = 1'b1;
        dones = 0;
        repeat (50) begin
            @(negedge CLOCK_50);
            if (done) dones++;
        end
        go = 1'b0;
        repeat (10) begin
            @(negedge CLOCK_50);
            if (done) dones++;
        end
        check("held go dones", dones, 1);
        check("held go sum", outs(), mk(8'h06, 1'b0, 1'b0, 1'b1, 1'b0));

        // Second edge lands while busy and must be dropped
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            go = (i == 0 || i == 2);
            @(negedge CLOCK_50);
            if (done) dones++;
        end
        go = 1'b0;
        check("edge during busy dones", dones, 1);
        check("edge during busy sum", outs(), mk(8'h07, 1'b0, 1'b0, 1'b1, 1'b0));

        // Async Reset after digit 0 has been written
        @(negedge CLOCK_50);
        SW_X = 8'h27;
        go   = 1'b1;
        @(negedge CLOCK_50);
        go = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("partial sum before reset", outs(), mk(8'h04, 1'b1, 1'b0, 1'b1, 1'b0));
        Reset = 1'b1;
        #1;
        check("async reset immediate", outs(), mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge CLOCK_50);
        Reset = 1'b0;
        dones = 0;
        repeat (10) begin
            @(negedge CLOCK_50);
            if (done || busy) dones++;
        end
        check("no activity after reset", dones, 0);
        check("sum after reset", outs(), mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));

        // Same abort with clr
        do_add("add 99", 8'h99, 8'h99, 1'b0);
        do_add("add 05 wrap", 8'h05, 8'h04, 1'b1);
        @(negedge CLOCK_50);
        SW_X = 8'h27;
        go   = 1'b1;
        @(negedge CLOCK_50);
        go = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        clr = 1'b1;
        #1;
        check("clr is synchronous", outs(), mk(8'h01, 1'b1, 1'b0, 1'b1, 1'b0));
        @(negedge CLOCK_50);
        check("clr at edge", outs(), mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        clr   = 1'b0;
        dones = 0;
        repeat (10) begin
            @(negedge CLOCK_50);
            if (done || busy) dones++;
        end
        check("no activity after clr", dones, 0);

        // clr also clears a sticky err
        bad_press(8'h0F, bcnt);
        check("err set again", outs(), mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        @(negedge CLOCK_50);
        clr = 1'b1;
        @(negedge CLOCK_50);
        clr = 1'b0;
        check("clr clears err", outs(), mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
